// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared select codes, state encoding and default widths for the n-body bus front end
package nbody_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int BODY_ADDR_WIDTH = 9;
  localparam int DATA_WIDTH      = 64;
  localparam int MAX_BODIES      = 512;

  localparam logic [6:0] SEL_GO       = 7'h00;
  localparam logic [6:0] SEL_READ     = 7'h01;
  localparam logic [6:0] SEL_N_BODIES = 7'h02;
  localparam logic [6:0] SEL_X        = 7'h03;
  localparam logic [6:0] SEL_Y        = 7'h04;
  localparam logic [6:0] SEL_M        = 7'h05;
  localparam logic [6:0] SEL_VX       = 7'h06;
  localparam logic [6:0] SEL_VY       = 7'h07;
  localparam logic [6:0] SEL_GAP      = 7'h08;
  localparam logic [6:0] SEL_DONE     = 7'h40;
  localparam logic [6:0] SEL_READ_X   = 7'h41;
  localparam logic [6:0] SEL_READ_Y   = 7'h42;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE_ST = 2'd2} state_t;

  // What the registered host read captured; readdata is rebuilt from this.
  typedef enum logic [1:0] {RD_ZERO = 2'd0, RD_DONE = 2'd1, RD_X = 2'd2, RD_Y = 2'd3} rd_kind_t;

endpackage

// File: rtl/nbody_body_mem.sv
// rtl/nbody_body_mem.sv - one-write, two-read synchronous RAM holding one per-body field
module nbody_body_mem #(
  parameter int AW    = 9,
  parameter int DW    = 64,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ra_en,
  input  logic [AW-1:0] i_ra_addr,
  output logic [DW-1:0] o_ra_q,
  input  logic [AW-1:0] i_rb_addr,
  output logic [DW-1:0] o_rb_q
);

  logic [DW-1:0] r_mem [DEPTH];

  // Port A holds its last value between enabled reads; port B follows its address every cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_ra_en) o_ra_q <= r_mem[i_ra_addr];
    o_rb_q <= r_mem[i_rb_addr];
  end

endmodule

// File: rtl/nbody_bus_if.sv
// rtl/nbody_bus_if.sv - Avalon-MM responder: register map, body memories and go/run/done sequencing
module nbody_bus_if #(
  parameter int ADDR_WIDTH      = nbody_pkg::ADDR_WIDTH,
  parameter int BODY_ADDR_WIDTH = nbody_pkg::BODY_ADDR_WIDTH,
  parameter int DATA_WIDTH      = nbody_pkg::DATA_WIDTH,
  parameter int MAX_BODIES      = nbody_pkg::MAX_BODIES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic                       read,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      writedata,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       core_go,
  output logic [BODY_ADDR_WIDTH:0]   core_n_bodies,
  output logic [DATA_WIDTH-1:0]      core_gap,
  input  logic [BODY_ADDR_WIDTH-1:0] core_rd_idx,
  output logic [DATA_WIDTH-1:0]      core_x,
  output logic [DATA_WIDTH-1:0]      core_y,
  output logic [DATA_WIDTH-1:0]      core_vx,
  output logic [DATA_WIDTH-1:0]      core_vy,
  output logic [DATA_WIDTH-1:0]      core_m,
  input  logic                       core_wr_en,
  input  logic [BODY_ADDR_WIDTH-1:0] core_wr_idx,
  input  logic [DATA_WIDTH-1:0]      core_wr_x,
  input  logic [DATA_WIDTH-1:0]      core_wr_y,
  input  logic [DATA_WIDTH-1:0]      core_wr_vx,
  input  logic [DATA_WIDTH-1:0]      core_wr_vy,
  input  logic                       core_done
);
  import nbody_pkg::*;

  localparam int SW = ADDR_WIDTH - BODY_ADDR_WIDTH;
  localparam logic [BODY_ADDR_WIDTH:0] MAX_N = (BODY_ADDR_WIDTH+1)'(MAX_BODIES);

  state_t                     r_state;
  logic                       r_done;
  logic                       r_core_go;
  logic                       r_readout_unused;
  logic [BODY_ADDR_WIDTH:0]   r_n_bodies;
  logic [DATA_WIDTH-1:0]      r_gap;
  rd_kind_t                   r_rd_kind;
  logic                       r_rd_done;

  logic [SW-1:0]              w_sel;
  logic [BODY_ADDR_WIDTH-1:0] w_idx;
  logic                       w_host_wr;
  logic                       w_host_rd;
  logic                       w_run;
  logic                       w_cfg_wr;
  logic                       w_body_wr;
  logic                       w_go;
  logic                       w_core_wb;
  logic                       w_rd_hit;
  logic [BODY_ADDR_WIDTH:0]   w_n_clamped;
  logic [BODY_ADDR_WIDTH-1:0] w_wb_addr;
  logic [DATA_WIDTH-1:0]      w_x_host, w_y_host;
  logic [DATA_WIDTH-1:0]      w_unused_vx, w_unused_vy, w_unused_m;

  assign w_sel       = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
  assign w_idx       = addr[BODY_ADDR_WIDTH-1:0];
  assign w_host_wr   = chipselect && write;
  assign w_host_rd   = chipselect && read && !write;
  assign w_run       = (r_state == RUN);
  assign w_cfg_wr    = w_host_wr && !w_run && (w_sel >= SEL_N_BODIES) && (w_sel <= SEL_GAP);
  assign w_body_wr   = w_host_wr && !w_run && ({1'b0, w_idx} < MAX_N);
  assign w_go        = w_host_wr && !w_run && (w_sel == SEL_GO) && writedata[0] && (r_n_bodies != '0);
  assign w_core_wb   = w_run && core_wr_en;
  assign w_rd_hit    = ({1'b0, w_idx} < r_n_bodies);
  assign w_n_clamped = (writedata > DATA_WIDTH'(MAX_BODIES)) ? MAX_N : writedata[BODY_ADDR_WIDTH:0];
  // Host and core writers are separated by state, so the address mux keys on RUN alone.
  assign w_wb_addr   = w_run ? core_wr_idx : w_idx;

  assign core_go       = r_core_go;
  assign core_n_bodies = r_n_bodies;
  assign core_gap      = r_gap;

  nbody_body_mem #(.AW(BODY_ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MAX_BODIES)) u_mem_x (
    .clk(clk), .i_we(w_core_wb || (w_body_wr && w_sel == SEL_X)), .i_waddr(w_wb_addr),
    .i_wdata(w_run ? core_wr_x : writedata), .i_ra_en(w_host_rd), .i_ra_addr(w_idx),
    .o_ra_q(w_x_host), .i_rb_addr(core_rd_idx), .o_rb_q(core_x));

  nbody_body_mem #(.AW(BODY_ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MAX_BODIES)) u_mem_y (
    .clk(clk), .i_we(w_core_wb || (w_body_wr && w_sel == SEL_Y)), .i_waddr(w_wb_addr),
    .i_wdata(w_run ? core_wr_y : writedata), .i_ra_en(w_host_rd), .i_ra_addr(w_idx),
    .o_ra_q(w_y_host), .i_rb_addr(core_rd_idx), .o_rb_q(core_y));

  nbody_body_mem #(.AW(BODY_ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MAX_BODIES)) u_mem_vx (
    .clk(clk), .i_we(w_core_wb || (w_body_wr && w_sel == SEL_VX)), .i_waddr(w_wb_addr),
    .i_wdata(w_run ? core_wr_vx : writedata), .i_ra_en(1'b0), .i_ra_addr(w_idx),
    .o_ra_q(w_unused_vx), .i_rb_addr(core_rd_idx), .o_rb_q(core_vx));

  nbody_body_mem #(.AW(BODY_ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MAX_BODIES)) u_mem_vy (
    .clk(clk), .i_we(w_core_wb || (w_body_wr && w_sel == SEL_VY)), .i_waddr(w_wb_addr),
    .i_wdata(w_run ? core_wr_vy : writedata), .i_ra_en(1'b0), .i_ra_addr(w_idx),
    .o_ra_q(w_unused_vy), .i_rb_addr(core_rd_idx), .o_rb_q(core_vy));

  nbody_body_mem #(.AW(BODY_ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MAX_BODIES)) u_mem_m (
    .clk(clk), .i_we(w_body_wr && w_sel == SEL_M), .i_waddr(w_idx),
    .i_wdata(writedata), .i_ra_en(1'b0), .i_ra_addr(w_idx),
    .o_ra_q(w_unused_m), .i_rb_addr(core_rd_idx), .o_rb_q(core_m));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_done           <= 1'b0;
      r_core_go        <= 1'b0;
      r_readout_unused <= 1'b0;
      r_n_bodies       <= '0;
      r_gap            <= '0;
      r_rd_kind        <= RD_ZERO;
      r_rd_done        <= 1'b0;
    end else begin
      r_core_go <= w_go;
      if (w_host_wr && w_sel == SEL_READ) r_readout_unused <= writedata[0];
      if (w_cfg_wr && w_sel == SEL_N_BODIES) r_n_bodies <= w_n_clamped;
      if (w_cfg_wr && w_sel == SEL_GAP) r_gap <= writedata;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= RUN;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            r_state <= DONE_ST;
            r_done  <= 1'b1;
          end
        end
        DONE_ST: begin
          if (w_go) begin
            r_state <= RUN;
            r_done  <= 1'b0;
          end else if (w_cfg_wr) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Capture the read decision; the matching RAM word is latched by port A on the same edge.
      if (w_host_rd) begin
        r_rd_done <= r_done && !w_run;
        if (w_sel == SEL_DONE) r_rd_kind <= RD_DONE;
        else if (w_sel == SEL_READ_X && w_rd_hit) r_rd_kind <= RD_X;
        else if (w_sel == SEL_READ_Y && w_rd_hit) r_rd_kind <= RD_Y;
        else r_rd_kind <= RD_ZERO;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (r_rd_kind)
      RD_DONE: readdata = DATA_WIDTH'(r_rd_done);
      RD_X:    readdata = w_x_host;
      RD_Y:    readdata = w_y_host;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nbody_bus_if.sv
// tb/tb_nbody_bus_if.sv - scoreboard bench for nbody_bus_if with a behavioural register-map model
module tb_nbody_bus_if;
  import nbody_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] writedata = '0;
  logic [63:0] readdata;
  logic        core_go;
  logic [9:0]  core_n_bodies;
  logic [63:0] core_gap;
  logic [8:0]  core_rd_idx = '0;
  logic [63:0] core_x, core_y, core_vx, core_vy, core_m;
  logic        core_wr_en = 1'b0;
  logic [8:0]  core_wr_idx = '0;
  logic [63:0] core_wr_x = '0, core_wr_y = '0, core_wr_vx = '0, core_wr_vy = '0;
  logic        core_done = 1'b0;

  nbody_bus_if dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .write(write), .read(read),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .core_go(core_go), .core_n_bodies(core_n_bodies), .core_gap(core_gap),
    .core_rd_idx(core_rd_idx), .core_x(core_x), .core_y(core_y), .core_vx(core_vx),
    .core_vy(core_vy), .core_m(core_m), .core_wr_en(core_wr_en), .core_wr_idx(core_wr_idx),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_vx(core_wr_vx),
    .core_wr_vy(core_wr_vy), .core_done(core_done));

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  // Reference model: plain arrays and a phase number.
  logic [63:0] mx [512], my [512], mvx [512], mvy [512], mm [512];
  int          mst = M_IDLE;
  int          mn = 0;
  logic [63:0] mgap = '0;
  logic        mdone = 1'b0;
  int          exp_go = 0;
  int          go_count = 0;

  typedef struct { string tag; logic [63:0] v; } exp_t;
  exp_t rd_q[$], cx_q[$], cm_q[$];
  logic [63:0] last_pushed = '0;

  int checks = 0, failures = 0;
  logic rd_pending = 1'b0, crd_pending = 1'b0, core_rd_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
    end
  endtask

  task automatic model_host_write(input logic [6:0] sel, input int idx, input logic [63:0] d);
    if (sel == SEL_GO) begin
      if (d[0] && mst != M_RUN && mn > 0) begin
        mst = M_RUN;
        mdone = 1'b0;
        exp_go++;
      end
    end else if (sel >= SEL_N_BODIES && sel <= SEL_GAP && mst != M_RUN) begin
      if (mst == M_DONE) begin
        mst = M_IDLE;
        mdone = 1'b0;
      end
      case (sel)
        SEL_N_BODIES: mn = (d > 64'd512) ? 512 : int'(d);
        SEL_X:  mx[idx] = d;
        SEL_Y:  my[idx] = d;
        SEL_M:  mm[idx] = d;
        SEL_VX: mvx[idx] = d;
        SEL_VY: mvy[idx] = d;
        SEL_GAP: mgap = d;
        default: ;
      endcase
    end
  endtask

  function automatic logic [63:0] model_read(input logic [6:0] sel, input int idx);
    if (sel == SEL_DONE) return (mst == M_RUN) ? 64'd0 : {63'd0, mdone};
    if (sel == SEL_READ_X) return (idx < mn) ? mx[idx] : 64'd0;
    if (sel == SEL_READ_Y) return (idx < mn) ? my[idx] : 64'd0;
    return 64'd0;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read result.
  always @(posedge clk) begin
    rd_pending  <= chipselect && read;
    crd_pending <= core_rd_req;
  end

  always @(negedge clk) begin
    exp_t e;
    if (core_go) go_count++;
    if (rd_pending) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 64'd1, 64'd0);
      else begin
        e = rd_q.pop_front();
        chk(e.tag, readdata, e.v);
      end
    end
    if (crd_pending) begin
      if (cx_q.size() == 0 || cm_q.size() == 0) chk("core_q_underflow", 64'd1, 64'd0);
      else begin
        e = cx_q.pop_front();
        chk(e.tag, core_x, e.v);
        e = cm_q.pop_front();
        chk(e.tag, core_m, e.v);
      end
    end
  end

  task automatic bus_write(input logic [6:0] sel, input int idx, input logic [63:0] d);
    logic [8:0] i9;
    i9 = idx[8:0];
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; addr = {sel, i9}; writedata = d;
    model_host_write(sel, idx, d);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [6:0] sel, input int idx);
    logic [8:0] i9;
    exp_t e;
    i9 = idx[8:0];
    @(negedge clk);
    chipselect = 1'b1; write = 1'b0; read = 1'b1; addr = {sel, i9};
    e.tag = tag; e.v = model_read(sel, idx);
    rd_q.push_back(e);
    last_pushed = e.v;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_rw(input logic [6:0] sel, input int idx, input logic [63:0] d);
    logic [8:0] i9;
    exp_t e;
    i9 = idx[8:0];
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b1; addr = {sel, i9}; writedata = d;
    model_host_write(sel, idx, d);
    e.tag = "rw_readdata_hold"; e.v = last_pushed;
    rd_q.push_back(e);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic core_wb(input int idx, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] vx, input logic [63:0] vy);
    @(negedge clk);
    core_wr_en = 1'b1; core_wr_idx = idx[8:0];
    core_wr_x = x; core_wr_y = y; core_wr_vx = vx; core_wr_vy = vy;
    if (mst == M_RUN) begin
      mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
    end
    @(posedge clk); #1;
    core_wr_en = 1'b0;
  endtask

  task automatic core_read(input int idx);
    exp_t e;
    @(negedge clk);
    core_rd_idx = idx[8:0]; core_rd_req = 1'b1;
    e.tag = "core_x"; e.v = mx[idx]; cx_q.push_back(e);
    e.tag = "core_m"; e.v = mm[idx]; cm_q.push_back(e);
    @(posedge clk); #1;
    core_rd_req = 1'b0;
  endtask

  task automatic core_finish();
    @(negedge clk);
    core_done = 1'b1;
    if (mst == M_RUN) begin
      mst = M_DONE;
      mdone = 1'b1;
    end
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  task automatic load_body(input int i, input real x, input real y, input real vx,
                           input real vy, input real m);
    bus_write(SEL_X, i, $realtobits(x));
    bus_write(SEL_Y, i, $realtobits(y));
    bus_write(SEL_VX, i, $realtobits(vx));
    bus_write(SEL_VY, i, $realtobits(vy));
    bus_write(SEL_M, i, $realtobits(m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int go_before;
    logic [6:0] rsel;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_readdata", readdata, 64'd0);
    chk("reset_core_go", {63'd0, core_go}, 64'd0);
    chk("reset_n_bodies", {54'd0, core_n_bodies}, 64'd0);
    chk("reset_gap", core_gap, 64'd0);
    bus_read("done_after_reset", SEL_DONE, 0);
    repeat (2) @(negedge clk);
    chk("go_count_idle", go_count, exp_go);

    // Fill every body slot so every later read has a defined model value.
    for (int i = 0; i < 512; i++) begin
      bus_write(SEL_X, i, {$urandom(), $urandom()});
      bus_write(SEL_Y, i, {$urandom(), $urandom()});
      bus_write(SEL_VX, i, {$urandom(), $urandom()});
      bus_write(SEL_VY, i, {$urandom(), $urandom()});
      bus_write(SEL_M, i, {$urandom(), $urandom()});
    end

    bus_write(SEL_N_BODIES, 0, 64'd25);
    load_body(0, 1.0, 10.0, 0.1, 0.0, 1000.0);
    load_body(1, -5.0, -15.0, 0.0, -0.05, 500.0);
    load_body(2, 20.0, 0.0, -0.2, 0.2, 2000.0);
    bus_write(SEL_GAP, 0, $realtobits(2.0));
    bus_write(SEL_GO, 0, 64'd1);
    repeat (3) @(negedge clk);
    chk("go_count_first", go_count, exp_go);
    chk("first_go_expected", exp_go, 1);
    chk("core_n_bodies_25", {54'd0, core_n_bodies}, 64'd25);
    chk("core_gap_2", core_gap, $realtobits(2.0));
    core_read(2);

    bus_write(SEL_X, 0, $realtobits(99.0));
    core_wb(0, $realtobits(1.5), $realtobits(10.0), $realtobits(0.1), 64'd0);
    bus_read("done_in_run", SEL_DONE, 0);
    core_finish();
    core_wb(0, $realtobits(77.0), 64'd0, 64'd0, 64'd0);
    bus_read("read_x0_updated", SEL_READ_X, 0);
    bus_read("read_y2", SEL_READ_Y, 2);
    bus_read("done_set", SEL_DONE, 0);
    bus_read("read_x30_out_of_range", SEL_READ_X, 30);
    bus_read("read_x24_last_valid", SEL_READ_X, 24);
    bus_read("read_unmapped_sel", 7'h43, 1);

    bus_rw(SEL_N_BODIES, 0, 64'd7);
    @(negedge clk); #1;
    chk("rw_n_applied", {54'd0, core_n_bodies}, 64'd7);
    bus_read("done_cleared_by_write", SEL_DONE, 0);

    bus_write(SEL_N_BODIES, 0, 64'd1000);
    @(negedge clk); #1;
    chk("n_clamp_512", {54'd0, core_n_bodies}, 64'd512);
    bus_write(SEL_N_BODIES, 0, 64'd0);
    go_before = go_count;
    bus_write(SEL_GO, 0, 64'd1);
    repeat (3) @(negedge clk);
    chk("go_with_n0_no_pulse", go_count, go_before);
    chk("go_count_n0", go_count, exp_go);

    bus_write(SEL_N_BODIES, 0, 64'd3);
    bus_write(SEL_GO, 0, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    mst = M_IDLE; mdone = 1'b0; mn = 0; mgap = '0; last_pushed = '0;
    #1;
    chk("midrun_reset_readdata", readdata, 64'd0);
    chk("midrun_reset_core_go", {63'd0, core_go}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read("done_after_midrun_reset", SEL_DONE, 0);
    bus_write(SEL_N_BODIES, 0, 64'd25);
    bus_write(SEL_GO, 0, 64'd1);
    repeat (3) @(negedge clk);
    chk("go_count_after_reset", go_count, exp_go);
    core_finish();

    // Randomised phase: idle traffic, a full run with core writebacks, then readback.
    bus_write(SEL_N_BODIES, 0, 64'($urandom_range(1, 512)));
    for (int k = 0; k < 30; k++)
      bus_write(7'($urandom_range(3, 7)), $urandom_range(0, 511), {$urandom(), $urandom()});
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: rsel = SEL_DONE;
        1, 2: rsel = SEL_READ_X;
        3: rsel = SEL_READ_Y;
        default: rsel = 7'($urandom_range(0, 127));
      endcase
      bus_read("rand_idle_read", rsel, $urandom_range(0, 511));
    end
    bus_write(SEL_GO, 0, 64'd1);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: core_wb($urandom_range(0, 511), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, {$urandom(), $urandom()});
        1: bus_write(7'($urandom_range(0, 8)), $urandom_range(0, 511), {$urandom(), $urandom()});
        2: core_read($urandom_range(0, 511));
        default: bus_read("rand_run_read", ($urandom_range(0, 1) != 0) ? SEL_READ_X : SEL_READ_Y,
                          $urandom_range(0, 511));
      endcase
    end
    core_finish();
    for (int k = 0; k < 30; k++) begin
      bus_read("rand_done_read", ($urandom_range(0, 1) != 0) ? SEL_READ_X : SEL_READ_Y,
               $urandom_range(0, 511));
      core_read($urandom_range(0, 511));
    end
    bus_read("rand_done_flag", SEL_DONE, 0);
    repeat (3) @(negedge clk);
    chk("go_count_final", go_count, exp_go);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("core_q_drained", 64'(cx_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nbody_bus_if.md
Name: nbody_bus_if

Overview:
- Avalon-MM responder front end for the n-body accelerator. It decodes the host register map, holds the per-body state memories (x, y, vx, vy, m), and sequences the compute core through go, run and done.
- The host CPU or bus master writes initial conditions, gap and go. It then polls done and reads back positions.
- The compute core reads and writes body memories through a dedicated side port.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- BODY_ADDR_WIDTH, 9, body index field width; select field is addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH] (7 bits).
- DATA_WIDTH, 64, bus and IEEE-754 double width.
- MAX_BODIES, 512, body memory depth; must be <= 2**BODY_ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- chipselect  in  1  bus select.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- addr  in  ADDR_WIDTH  {sel[6:0], idx[8:0]}.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  registered read data.
- core_go  out  1  one-cycle start pulse to core.
- core_n_bodies  out  BODY_ADDR_WIDTH+1  body count.
- core_gap  out  DATA_WIDTH  gap register.
- core_rd_idx  in  BODY_ADDR_WIDTH  core memory read index.
- core_x, core_y, core_vx, core_vy, core_m  out  DATA_WIDTH each  read data, valid 1 cycle after core_rd_idx.
- core_wr_en  in  1  core writeback strobe.
- core_wr_idx  in  BODY_ADDR_WIDTH  writeback index.
- core_wr_x, core_wr_y, core_wr_vx, core_wr_vy  in  DATA_WIDTH each  writeback data.
- core_done  in  1  core finished pulse/level.

Behaviour:
- Reset (rst_n low, async)
  - readdata=0, core_go=0, n_bodies=0, gap=0, done=0, readout=0, state=IDLE.
  - Memory contents are not cleared.
- Bus access
  - Access occurs only when chipselect=1. sel=addr[15:9], idx=addr[8:0].
  - If write and read are both high, the write wins and readdata holds.
- Write map
  - 0x00 GO: writedata[0]=1 requests start.
  - 0x01 READ: readout<=writedata[0].
  - 0x02 N_BODIES: saturating clamp to MAX_BODIES.
  - 0x03 X, 0x04 Y, 0x05 M, 0x06 VX, 0x07 VY: write mem[idx].
  - 0x08 GAP.
  - Any other sel: ignored.
  - Writes with idx>=MAX_BODIES are ignored.
- Read map
  - 0x40 DONE: {63'b0, done}.
  - 0x41 READ_X: x[idx]. 0x42 READ_Y: y[idx].
  - idx>=n_bodies returns 0. Any other sel returns 0.
- Read latency: readdata is registered on the clk edge sampling read, so it is valid 1 cycle later and holds until the next read.
- State IDLE
  - Body, N and GAP writes are accepted.
  - GO with n_bodies>0: core_go=1 for exactly one cycle (next cycle), done<=0, go to RUN.
  - GO with n_bodies=0 is ignored.
- State RUN
  - Host writes to body memories, N_BODIES and GAP are ignored. GO is ignored.
  - core_wr_en writes x/y/vx/vy[core_wr_idx] each cycle.
  - DONE reads return 0.
  - core_done=1 -> done<=1, go to DONE_ST.
- State DONE_ST
  - READ_X/READ_Y return updated values. core_wr_en is ignored.
  - GO (n_bodies>0) restarts the core with a fresh core_go pulse and moves to RUN.
  - Any body, N or GAP write clears done and moves to IDLE; the write itself is performed.
- Memories
  - Synchronous single-write per array.
  - Port priority: core writeback in RUN, host writes otherwise. They never share a cycle, by state gating.
  - Host readback and core read use independent read ports (true dual-port or duplicated RAM).
- Reset mid-RUN: state returns to IDLE, done=0, core_go=0. The core must be reset by the same rst_n.

Decomposition:
- Package nbody_pkg holds:
  - the select codes (GO..GAP, DONE, READ_X, READ_Y);
  - state enum {IDLE, RUN, DONE_ST};
  - ADDR_WIDTH/BODY_ADDR_WIDTH/DATA_WIDTH defaults.
- One sub-module, nbody_body_mem: a 1-write/2-read synchronous RAM, instantiated once per field (5 instances).

Test Plan:
- Reset, then read DONE: readdata=0 one cycle later; core_go stays 0.
- Write N=25; bodies 0..2 loaded with (x,y,vx,vy,m) = (1,10,0.1,0,1000), (-5,-15,0,-0.05,500), (20,0,-0.2,0.2,2000); GAP=2; GO=1.
  - Exactly one core_go cycle; core_n_bodies=25; core_gap=2.
  - core_rd_idx=2 returns core_x=20.0 one cycle later.
- In RUN, host write X[0]=99.0 and core writeback idx0 x=1.5 in separate cycles.
  - Then core_done; READ_X idx0 = 1.5 and DONE reads 1.
- N_BODIES=1000 clamps to 512. READ_X idx 30 with N=25 returns 0. GO with N=0 produces no core_go.
- Assert rst_n low mid-RUN.
  - State=IDLE, readdata=0, done=0.
  - Subsequent GO with N reloaded restarts with a single core_go pulse.
- Simultaneous read+write to N_BODIES: the write is applied and readdata is unchanged from the prior read.
